psg_ecfs_lvdcdc_sd_mod: RTL and testbench

//  Digital 2nd-order sigma-delta modulator. Converts 16-bit signed samples to a 1-bit stream.
//  The stream is in the format the SD-ADC decimator consumes: 1 = positive, ones density = 0.5 + x/65536.

---
 rtl/psg_ecfs_lvdcdc_sd_mod.sv | 169 ++++++++++++++++
 tb/tb_psg_ecfs_lvdcdc_sd_mod.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_ecfs_lvdcdc_sd_mod.sv
// Second-order sigma-delta modulator: 16-bit signed samples in, 1-bit stream out
// (ones density = 0.5 + x/65536), framed to match the SD-ADC decimator period.
module psg_ecfs_lvdcdc_sd_mod #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned DECIMATION  = 128,
  parameter int          INPUT_LIMIT = 26214
) (
  input  logic        clk_adc,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  output logic        sample_in_ready,
  input  logic        clear_overload,
  output logic        dat_out,
  output logic        bit_strobe,
  output logic        frame_tick,
  output logic        running,
  output logic        overload
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  localparam logic signed [15:0] LIM_POS  = 16'(INPUT_LIMIT);
  localparam logic signed [15:0] LIM_NEG  = -16'(INPUT_LIMIT);
  localparam logic signed [24:0] FB_POS   = 25'sd32768;
  localparam logic signed [24:0] FB_NEG   = -25'sd32768;
  localparam logic signed [24:0] INT1_MAX = 25'sd524287;
  localparam logic signed [24:0] INT1_MIN = -25'sd524288;
  localparam logic signed [24:0] INT2_MAX = 25'sd8388607;
  localparam logic signed [24:0] INT2_MIN = -25'sd8388608;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [FRM_W-1:0]   frm_q;
  logic               tick, wrap;
  logic               pend_full_q, accept;
  logic signed [15:0] pending_q, active_q, sample_s, clamped;
  logic               clamp_hit;
  logic signed [19:0] int1_q, int1_nxt;
  logic signed [23:0] int2_q, int2_nxt;
  logic signed [24:0] fb, d1, int1_ext, sum1, sum2;
  logic               sat1, sat2, loop_en, set_ovl;
  logic               dat_q, strobe_q, ftick_q, ovl_q;

  assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
  assign wrap    = tick && (frm_q == FRM_W'(DECIMATION - 1));
  assign accept  = sample_in_valid && !pend_full_q;
  assign loop_en = tick && (state_q == RUN) && enable;
  assign set_ovl = (accept && clamp_hit) || (loop_en && (sat1 || sat2));

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    sample_s  = $signed(sample_in);
    clamped   = sample_s;
    clamp_hit = 1'b0;
    if (sample_s > LIM_POS) begin
      clamped   = LIM_POS;
      clamp_hit = 1'b1;
    end else if (sample_s < LIM_NEG) begin
      clamped   = LIM_NEG;
      clamp_hit = 1'b1;
    end
  end

  // Both integrator updates use the pre-edge int1; sums are formed at 25 bits so they cannot wrap.
  always_comb begin
    fb       = dat_q ? FB_POS : FB_NEG;
    d1       = $signed({{9{active_q[15]}}, active_q}) - fb;
    int1_ext = $signed({{5{int1_q[19]}}, int1_q});
    sum1     = int1_ext + d1;
    sum2     = $signed({int2_q[23], int2_q}) + int1_ext + d1 - fb;
    int1_nxt = sum1[19:0];
    sat1     = 1'b0;
    if (sum1 > INT1_MAX) begin
      int1_nxt = INT1_MAX[19:0];
      sat1     = 1'b1;
    end else if (sum1 < INT1_MIN) begin
      int1_nxt = INT1_MIN[19:0];
      sat1     = 1'b1;
    end
    int2_nxt = sum2[23:0];
    sat2     = 1'b0;
    if (sum2 > INT2_MAX) begin
      int2_nxt = INT2_MAX[23:0];
      sat2     = 1'b1;
    end else if (sum2 < INT2_MIN) begin
      int2_nxt = INT2_MIN[23:0];
      sat2     = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wrap && enable) state_d = RUN;
      RUN:     if (tick && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      frm_q    <= '0;
      strobe_q <= 1'b0;
      ftick_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      div_q    <= tick ? '0 : div_q + DIV_W'(1);
      if (tick) frm_q <= (frm_q == FRM_W'(DECIMATION - 1)) ? '0 : frm_q + FRM_W'(1);
      strobe_q <= tick;
      ftick_q  <= wrap;
      state_q  <= state_d;
    end
  end

  // Pending only drains on a frame wrap, so accept and transfer never coincide.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      pend_full_q <= 1'b0;
      pending_q   <= '0;
      active_q    <= '0;
    end else if (wrap && pend_full_q) begin
      active_q    <= pending_q;
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pending_q   <= clamped;
      pend_full_q <= 1'b1;
    end
  end

  // Outside RUN the integrators sit at zero and the output toggles as a midscale pattern.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      int1_q <= '0;
      int2_q <= '0;
      dat_q  <= 1'b0;
    end else if (tick) begin
      if (loop_en) begin
        int1_q <= int1_nxt;
        int2_q <= int2_nxt;
        dat_q  <= !int2_nxt[23];
      end else begin
        int1_q <= '0;
        int2_q <= '0;
        dat_q  <= !dat_q;
      end
    end
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n)            ovl_q <= 1'b0;
    else if (set_ovl)        ovl_q <= 1'b1;
    else if (clear_overload) ovl_q <= 1'b0;
  end

  assign sample_in_ready = !pend_full_q;
  assign dat_out         = dat_q;
  assign bit_strobe      = strobe_q;
  assign frame_tick      = ftick_q;
  assign running         = (state_q == RUN);
  assign overload        = ovl_q;

endmodule

// File: tb/tb_psg_ecfs_lvdcdc_sd_mod.sv
// Bench for the sigma-delta modulator: ones density is checked against 0.5 + x/65536,
// plus handshake, framing, idle pattern, overload and reset timing.
module tb_psg_ecfs_lvdcdc_sd_mod;

  localparam int LIMIT = 26214;

  logic        clk_adc = 1'b0;
  logic        reset_n, reset_n4, enable, sample_in_valid, clear_overload;
  logic [15:0] sample_in;
  logic        sample_in_ready, dat_out, bit_strobe, frame_tick, running, overload;
  logic        ready4, dat4, strobe4, ftick4, run4, ovl4;

  int n_tests = 0;
  int n_fail  = 0;
  logic model_ovl = 1'b0;
  int t4_vals[3] = '{12288, -12288, 0};

  always #5 clk_adc = ~clk_adc;

  psg_ecfs_lvdcdc_sd_mod #(.CLK_DIV(1), .DECIMATION(128), .INPUT_LIMIT(LIMIT)) u_dut (
    .clk_adc(clk_adc), .reset_n(reset_n), .enable(enable),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(sample_in_ready),
    .clear_overload(clear_overload), .dat_out(dat_out), .bit_strobe(bit_strobe),
    .frame_tick(frame_tick), .running(running), .overload(overload)
  );

  psg_ecfs_lvdcdc_sd_mod #(.CLK_DIV(4), .DECIMATION(128), .INPUT_LIMIT(LIMIT)) u_dut4 (
    .clk_adc(clk_adc), .reset_n(reset_n4), .enable(enable),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(ready4),
    .clear_overload(clear_overload), .dat_out(dat4), .bit_strobe(strobe4),
    .frame_tick(ftick4), .running(run4), .overload(ovl4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    n_tests++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Ideal ones count for n output bits at constant input a.
  function automatic int exp_ones(input int n, input int a);
    real r;
    r = n * (0.5 + a / 65536.0);
    return $rtoi(r + 0.5);
  endfunction

  function automatic int clamp_val(input int x);
    if (x > LIMIT)  return LIMIT;
    if (x < -LIMIT) return -LIMIT;
    return x;
  endfunction

  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_adc);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic send(input int x, input logic clr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (sample_in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk_adc);
    end
    check("send_ready", ok, 1);
    sample_in       = 16'(x);
    sample_in_valid = 1'b1;
    clear_overload  = clr;
    if (clamp_val(x) != x) model_ovl = 1'b1;
    else if (clr)          model_ovl = 1'b0;
    @(negedge clk_adc);
    sample_in_valid = 1'b0;
    clear_overload  = 1'b0;
    check("ready_falls_after_accept", sample_in_ready, 0);
    check("overload_after_accept", overload, model_ovl);
  endtask

  // Caller sits on a frame_tick sample; counts dat_out over the next n bits.
  task automatic measure(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(dat_out);
      @(negedge clk_adc);
    end
  endtask

  // Step to a frame where x is active and settled, then check density over 8 frames.
  task automatic density(input string tag, input int x, input int tol);
    int ones;
    send(x, 1'b0);
    wait_frame({tag, "_load"});
    wait_frame({tag, "_settle"});
    measure(1024, ones);
    check_near(tag, ones, exp_ones(1024, clamp_val(x)), tol);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, ones, prev, x;
    int idx, frame_a, frames_done, m_pend, m_active;
    bit m_full, meas, prev_ready, accepted;

    reset_n = 1'b0; reset_n4 = 1'b0; enable = 1'b0;
    sample_in = '0; sample_in_valid = 1'b0; clear_overload = 1'b0;
    repeat (3) @(negedge clk_adc);
    check("rst_dat_out", dat_out, 0);
    check("rst_bit_strobe", bit_strobe, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_running", running, 0);
    check("rst_overload", overload, 0);
    check("rst_ready", sample_in_ready, 1);

    // Idle after release: strobe held high, midscale toggle, first frame at bit 128.
    reset_n = 1'b1; reset_n4 = 1'b1;
    first = 0;
    for (int c = 1; c <= 300 && first == 0; c++) begin
      @(negedge clk_adc);
      if (c <= 6) begin
        check("idle_strobe_held", bit_strobe, 1);
        check("idle_pattern", dat_out, c % 2);
      end
      if (frame_tick === 1'b1) first = c;
    end
    check("first_frame_tick_cycle", first, 128);
    check("idle_running", running, 0);

    // T1: zero input, 64 ones per frame.
    send(0, 1'b0);
    enable = 1'b1;
    wait_frame("t1_start");
    check("t1_running_with_tick", running, 1);
    wait_frame("t1_settle");
    measure(128, ones);
    check_near("t1_frame_a", ones, 64, 1);
    measure(128, ones);
    check_near("t1_frame_b", ones, 64, 1);
    check("t1_overload", overload, 0);

    // T2 and random samples within +/-0.5 FS.
    density("t2_pos", 16384, 2);
    density("t2_neg", -16384, 2);
    for (int k = 0; k < 3; k++) begin
      x = int'($urandom_range(32768)) - 16384;
      density($sformatf("rand_%0d", x), x, 3);
    end
    check("t2_overload", overload, 0);

    // T3: clamp at both rails, sticky overload, clear, and set-over-clear priority.
    density("t3_pos_clamp", 32767, 8);
    check("t3_overload_sticky", overload, 1);
    clear_overload = 1'b1;
    @(negedge clk_adc);
    clear_overload = 1'b0;
    model_ovl = 1'b0;
    check("t3_overload_cleared", overload, 0);
    send(-32768, 1'b1);
    wait_frame("t3n_load");
    wait_frame("t3n_settle");
    measure(1024, ones);
    check_near("t3_neg_clamp", ones, exp_ones(1024, -LIMIT), 8);
    clear_overload = 1'b1;
    @(negedge clk_adc);
    clear_overload = 1'b0;
    model_ovl = 1'b0;
    send(LIMIT, 1'b0);
    check("t3_limit_no_overload", overload, 0);
    send(0, 1'b0);
    wait_frame("t4_prep");

    // T4: valid held across three samples; one transfer per frame, none lost or repeated.
    m_full = 1'b0; m_active = 0; m_pend = 0; meas = 1'b0;
    idx = 0; frames_done = 0; ones = 0; frame_a = 0;
    sample_in = 16'(t4_vals[0]);
    sample_in_valid = 1'b1;
    prev_ready = sample_in_ready;
    for (int c = 0; c < 1000 && frames_done < 3; c++) begin
      @(negedge clk_adc);
      accepted = (sample_in_valid === 1'b1) && prev_ready;
      if (frame_tick === 1'b1) begin
        if (meas) begin
          check_near($sformatf("t4_frame_%0d", frames_done), ones, exp_ones(128, frame_a), 6);
          frames_done++;
        end
        meas = m_full;
        if (m_full) begin
          m_active = m_pend;
          m_full   = 1'b0;
          frame_a  = m_active;
        end
        ones = 0;
      end
      if (accepted) begin
        m_pend = t4_vals[idx];
        m_full = 1'b1;
        idx++;
        if (idx < 3) sample_in = 16'(t4_vals[idx]);
        else sample_in_valid = 1'b0;
      end
      check("t4_ready", sample_in_ready, !m_full);
      ones += int'(dat_out);
      prev_ready = sample_in_ready;
    end
    sample_in_valid = 1'b0;
    check("t4_frames_checked", frames_done, 3);
    check("t4_samples_taken", idx, 3);

    // T5: drop enable -> idle toggle; re-enable -> running rises with the next frame_tick.
    enable = 1'b0;
    @(negedge clk_adc);
    check("t5_running_low", running, 0);
    prev = int'(dat_out);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_adc);
      check("t5_alternate", dat_out ^ prev[0], 1);
      prev = int'(dat_out);
    end
    enable = 1'b1;
    first = 0;
    for (int c = 0; c < 400 && first == 0; c++) begin
      @(negedge clk_adc);
      if (frame_tick === 1'b1) first = 1;
      else if (running !== 1'b0) first = 2;
    end
    check("t5_rerun_at_frame_tick", first, 1);
    check("t5_running_high", running, 1);

    // T6: CLK_DIV=4 instance, reset asserted right after a strobe, mid-frame.
    first = 0;
    for (int c = 0; c < 10 && first == 0; c++) begin
      @(negedge clk_adc);
      if (strobe4 === 1'b1) first = 1;
    end
    check("t6_strobe_before_reset", first, 1);
    #2 reset_n4 = 1'b0;
    #1;
    check("t6_rst_strobe", strobe4, 0);
    check("t6_rst_dat", dat4, 0);
    check("t6_rst_frame_tick", ftick4, 0);
    check("t6_rst_running", run4, 0);
    check("t6_rst_overload", ovl4, 0);
    check("t6_rst_ready", ready4, 1);
    @(negedge clk_adc);
    reset_n4 = 1'b1;
    first = 0; prev = 0;
    for (int c = 1; c <= 700 && first == 0; c++) begin
      @(negedge clk_adc);
      if (strobe4 === 1'b1 && prev == 0) prev = c;
      if (ftick4 === 1'b1) first = c;
    end
    check("t6_first_strobe_cycle", prev, 4);
    check("t6_first_frame_tick_cycle", first, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
